uart_tx_buffered: RTL and testbench

Parametrised successor to the single-byte UART transmitter. Adds an input FIFO, so several words can be queued while a frame is on the line. Adds configurable stop bits and optional parity. Sits between the command translator and the robot's serial link, driving uart_out at CLKS_PER_BIT clocks per bit.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, default baud divisor and parity helper for the buffered UART transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR reduction unchanged.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count; pushes into a full FIFO are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;

    assign dout  = mem_q[rd_q];
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with 1 or 2 stop bits and back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int BITS_N       = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS_N-1:0]             data_tx,
    input  logic                          valid,
    output logic                          tx_ready,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_N);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              uart_out_q, uart_out_d;
    logic              overflow_q, overflow_d;
    logic [BITS_N-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, push, pop, load, baud_last;

    sync_fifo #(.WIDTH(BITS_N), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_tx),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shift register is consumed during DATA.
    logic par_q, par_d;
    always_comb par_d = pop ? parity_calc(9'(fifo_dout), PARITY_ODD != 0) : par_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) par_q <= 1'b0;
        else par_q <= par_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD != 0;
`endif

    always_comb begin
        push       = valid && !fifo_full;
        overflow_d = valid && fifo_full;
        baud_last  = baud_q == CW'(CLKS_PER_BIT - 1);
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        uart_out_d = uart_out_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d     = '0;
                uart_out_d = 1'b1;
                load       = !fifo_empty;
            end
            START: if (baud_last) begin
                state_d    = DATA;
                baud_d     = '0;
                idx_d      = '0;
                uart_out_d = shift_q[0];
            end
            DATA: if (baud_last) begin
                baud_d     = '0;
                shift_d    = shift_q >> 1;
                idx_d      = idx_q + 1'b1;
                uart_out_d = shift_q[1];
                if (idx_q == BW'(BITS_N - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d    = PARITY;
                    uart_out_d = par_q;
`else
                    state_d    = STOP;
                    idx_d      = '0;
                    uart_out_d = 1'b1;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_last) begin
                state_d    = STOP;
                baud_d     = '0;
                idx_d      = '0;
                uart_out_d = 1'b1;
            end
`endif
            STOP: if (baud_last) begin
                baud_d = '0;
                idx_d  = idx_q + 1'b1;
                if (idx_q == BW'(STOP_BITS - 1)) begin
                    state_d    = IDLE;
                    uart_out_d = 1'b1;
                    load       = !fifo_empty;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading straight from STOP is what removes the idle gap between queued frames.
        pop = load;
        if (load) begin
            state_d    = START;
            baud_d     = '0;
            shift_d    = fifo_dout;
            uart_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            uart_out_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            uart_out_q <= uart_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_ready = !fifo_full;
    assign uart_out = uart_out_q;
    assign overflow = overflow_q;
    assign busy     = state_q != IDLE || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: frame-timing reference model checked every cycle, plus table vectors and directed corner cases.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int NB    = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL  = (2 + NB + P) * CPB;
    localparam int FL2 = (3 + NB + P) * CPB;

    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, valid2 = 1'b0;
    logic [7:0] data_tx = 8'h00, data2 = 8'h00;
    logic       tx_ready, uart_out, busy, overflow;
    logic       tx_ready2, uart_out2, busy2, overflow2;
    logic [2:0] fifo_count, fifo_count2;

    int         checks = 0, errors = 0, cyc = 0, last_end = 0;
    int         q_acc[$], q_start[$];
    logic [7:0] q_data[$];

    typedef struct {
        logic [7:0]  d;
        logic [11:0] bits;
        int          nb;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .BITS_N(NB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .data_tx(data_tx), .valid(valid), .tx_ready(tx_ready),
        .uart_out(uart_out), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .BITS_N(NB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst(rst), .data_tx(data2), .valid(valid2), .tx_ready(tx_ready2),
        .uart_out(uart_out2), .busy(busy2), .fifo_count(fifo_count2), .overflow(overflow2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Line level of a frame k bit periods after its start: start, data LSB first, [parity], stop.
    function automatic logic frame_bit(logic [7:0] d, int k);
        logic b;
        b = 1'b1;
        if (k == 0) b = 1'b0;
        else if (k <= NB) b = d[k-1];
        else if (P == 1 && k == NB + 1) b = ^d;
        return b;
    endfunction

    function automatic int m_count(int e);
        int n = 0;
        foreach (q_acc[i]) if (q_acc[i] <= e && q_start[i] > e) n++;
        return n;
    endfunction

    function automatic logic m_line(int e);
        logic b = 1'b1;
        foreach (q_start[i])
            if (e >= q_start[i] && e < q_start[i] + FL) b = frame_bit(q_data[i], (e - q_start[i]) / CPB);
        return b;
    endfunction

    function automatic logic m_busy(int e);
        return q_start.size() != 0 && q_start[$] + FL > e;
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        logic rdy;
        valid   = v;
        data_tx = d;
        rdy     = m_count(cyc) < DEPTH;
        @(posedge clk);
        cyc++;
        if (v && rdy) begin
            q_acc.push_back(cyc);
            q_data.push_back(d);
            q_start.push_back(cyc + 1 > last_end ? cyc + 1 : last_end);
            last_end = q_start[$] + FL;
        end
        #1;
        chk("uart_out", uart_out, m_line(cyc));
        chk("busy", busy, m_busy(cyc));
        chk("fifo_count", fifo_count, m_count(cyc));
        chk("tx_ready", tx_ready, m_count(cyc) < DEPTH);
        chk("overflow", overflow, v && !rdy);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((busy || m_busy(cyc)) && n < limit) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("drain_in_time", n < limit, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s, hi, peak;
        logic all_ready;
`ifdef UART_TX_PARITY_EN
        tbl[0] = '{8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0}, 11};
        tbl[1] = '{8'h00, {2'b11, 1'b0, 8'h00, 1'b0}, 11};
        tbl[2] = '{8'hFF, {2'b11, 1'b0, 8'hFF, 1'b0}, 11};
        tbl[3] = '{8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 11};
        tbl[4] = '{8'h80, {2'b11, 1'b1, 8'h80, 1'b0}, 11};
`else
        tbl[0] = '{8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}, 10};
        tbl[1] = '{8'h00, {2'b11, 1'b1, 8'h00, 1'b0}, 10};
        tbl[2] = '{8'hFF, {2'b11, 1'b1, 8'hFF, 1'b0}, 10};
        tbl[3] = '{8'h07, {2'b11, 1'b1, 8'h07, 1'b0}, 10};
        tbl[4] = '{8'h80, {2'b11, 1'b1, 8'h80, 1'b0}, 10};
`endif
        repeat (3) @(negedge clk);
        chk("rst_uart_out", uart_out, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].d);
            s = cyc + 1;
            chk("write_edge_line_high", uart_out, 1'b1);
            while (cyc < s + FL + 2) begin
                step(1'b0, 8'h00);
                if ((cyc - s) % CPB == CPB / 2 && cyc - s < tbl[i].nb * CPB)
                    chk("mid_bit", uart_out, tbl[i].bits[(cyc - s) / CPB]);
                if (cyc == s) chk("start_edge", uart_out, 1'b0);
                if (cyc == s + FL - 1) chk("busy_last_cycle", busy, 1'b1);
                if (cyc == s + FL) chk("busy_done", busy, 1'b0);
            end
        end

        step(1'b1, 8'h11);
        s = cyc + 1;
        peak = fifo_count;
        all_ready = tx_ready;
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 8'(i * 8'h11));
            if (fifo_count > peak) peak = fifo_count;
            all_ready &= tx_ready;
        end
        chk("burst_peak", peak, 3);
        chk("burst_ready", all_ready, 1'b1);
        while (cyc < s + 4 * FL + 2) begin
            step(1'b0, 8'h00);
            for (int j = 0; j < 4; j++) begin
                if (cyc == s + j * FL) chk("burst_start", uart_out, 1'b0);
                if (j > 0 && cyc == s + j * FL - 1) chk("burst_stop_before_start", uart_out, 1'b1);
            end
        end
        chk("burst_idle", busy, 1'b0);

        step(1'b1, 8'h5A);
        repeat (3) step(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'hC0 + i));
            if (i == 3) begin
                chk("ovf_full_count", fifo_count, 4);
                chk("ovf_full_ready", tx_ready, 1'b0);
            end
            if (i == 4) begin
                chk("ovf_pulse", overflow, 1'b1);
                chk("ovf_count_held", fifo_count, 4);
            end
        end
        step(1'b0, 8'h00);
        chk("ovf_one_cycle", overflow, 1'b0);
        drain(7 * FL);

        repeat (600) step($urandom_range(0, 11) == 0, 8'($urandom));
        drain(8 * FL);

        valid2 = 1'b1;
        data2  = 8'hFF;
        step(1'b0, 8'h00);
        s = cyc + 1;
        chk("stop2_write_line_high", uart_out2, 1'b1);
        data2 = 8'h00;
        step(1'b0, 8'h00);
        valid2 = 1'b0;
        hi = 0;
        while (cyc < s + 2 * FL2 + 2) begin
            step(1'b0, 8'h00);
            if (cyc >= s + FL2 - 2 * CPB && cyc < s + FL2) hi += int'(uart_out2);
            if (cyc == s) chk("stop2_first_start", uart_out2, 1'b0);
            if (cyc == s + FL2) chk("stop2_next_start", uart_out2, 1'b0);
        end
        chk("stop2_high_cycles", hi, 2 * CPB);
        chk("stop2_busy_done", busy2, 1'b0);
        chk("stop2_ready", tx_ready2, 1'b1);
        chk("stop2_count", fifo_count2, 0);
        chk("stop2_overflow", overflow2, 1'b0);

        step(1'b1, 8'h52);
        s = cyc + 1;
        step(1'b1, 8'h3C);
        step(1'b1, 8'hC3);
        while (cyc < s + 4 * CPB + CPB / 2) step(1'b0, 8'h00);
        chk("pre_rst_line", uart_out, 1'b0);
        chk("pre_rst_count", fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_uart_out", uart_out, 1'b1);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_busy", busy, 1'b0);
        valid   = 1'b1;
        data_tx = 8'hEE;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_count", fifo_count, 0);
        chk("rst_hold_busy", busy, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b0;
        q_acc.delete();
        q_start.delete();
        q_data.delete();
        last_end = 0;
        repeat (3 * FL) step(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
